// File: rtl/wb_burst_slave_mem_if.sv
// Wishbone B3 bus bundle between the DMA master and wb_burst_slave_mem.
// The slave modport drives read data and both terminations.
interface wb_burst_slave_mem_if;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  modport master (output adr, sel, we, dat_w, cyc, stb, cti, bte,
                  input  dat_r, ack, err);
  modport slave  (input  adr, sel, we, dat_w, cyc, stb, cti, bte,
                  output dat_r, ack, err);
endinterface

// File: rtl/wb_burst_slave_mem.sv
// Wishbone B3 slave memory with wait states, byte lanes and error termination.
// Define WB_BURST_SLAVE_MEM_BURST_EN to add CTI/BTE incrementing and wrapping bursts.
module wb_burst_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  wb_burst_slave_mem_if.slave        bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT, ACK, BURST, GAP, ERR} state_t;

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [AW-1:0] idx, idx_d, rd_idx, req_idx;
  logic          ack_q, ack_d, err_q, err_d;
  logic [31:0]   dat_q, offset;
  logic          req, in_range, wr_en;
  logic [31:0]   mem [DEPTH];

  assign req      = bus.cyc & bus.stb;
  assign offset   = bus.adr - BASE_ADDR;
  assign in_range = (bus.adr >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH));
  assign req_idx  = offset[AW+1:2];

  // Burst acks are armed a cycle ahead; a stalled strobe masks the armed ack.
  assign bus.ack   = ack_q & ((state != BURST) | bus.stb);
  assign bus.err   = err_q;
  assign bus.dat_r = dat_q;

  assign wr_en = bus.ack & bus.we & req & ~wb_rst_i;

`ifdef WB_BURST_SLAVE_MEM_BURST_EN
  logic [AW-1:0] wrap_mask, nxt_idx;
  logic          nxt_out;

  always_comb begin
    unique case (bus.bte)
      2'b01:   wrap_mask = AW'(3);
      2'b10:   wrap_mask = AW'(7);
      2'b11:   wrap_mask = AW'(15);
      default: wrap_mask = '1;
    endcase
  end

  // Wrapping bursts only advance the low index bits; linear ones may run off the end.
  assign nxt_idx = (idx & ~wrap_mask) | ((idx + 1'b1) & wrap_mask);
  assign nxt_out = (bus.bte == 2'b00) && (idx == AW'(DEPTH - 1));
`else
  logic unused_burst_inputs;
  assign unused_burst_inputs = ^{bus.cti, bus.bte};
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    rd_idx  = idx;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          idx_d  = req_idx;
          rd_idx = req_idx;
          if (!in_range) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_d = ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt == 4'd0) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ACK: begin
        state_d = GAP;
`ifdef WB_BURST_SLAVE_MEM_BURST_EN
        if (bus.cti == 3'b010 && req) begin
          if (nxt_out) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = BURST;
            ack_d   = 1'b1;
            idx_d   = nxt_idx;
            rd_idx  = nxt_idx;
          end
        end
`endif
      end
`ifdef WB_BURST_SLAVE_MEM_BURST_EN
      BURST: begin
        ack_d = 1'b1;
        if (!bus.cyc) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end else if (bus.stb) begin
          if (bus.cti != 3'b010) begin
            state_d = GAP;
            ack_d   = 1'b0;
          end else if (nxt_out) begin
            state_d = ERR;
            ack_d   = 1'b0;
            err_d   = 1'b1;
          end else begin
            idx_d  = nxt_idx;
            rd_idx = nxt_idx;
          end
        end
      end
`endif
      ERR:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      ack_q <= ack_d;
      err_q <= err_d;
      if (ack_d) dat_q <= mem[rd_idx];
    end
  end

  // NOTE: the array has no reset so it can map onto block RAM; reset only blocks the write strobe.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sel[b]) mem[idx][8*b +: 8] <= bus.dat_w[8*b +: 8];
      end
    end
  end
endmodule

// File: doc/wb_burst_slave_mem.md
Name: wb_burst_slave_mem

Overview:
- Synthesizable Wishbone B3 slave memory that sits directly downstream of the Ethernet MAC's DMA master port and serves its descriptor and buffer reads and writes.
- Supports classic cycles with programmable wait states and incrementing/wrapping bursts (CTI/BTE).
- Supports byte-lane writes and error termination for out-of-range addresses.
- Replaces the behavioural memory model in system-level simulation and is usable on FPGA.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- DEPTH, 1024: number of 32-bit words; power of two.
- WAIT_STATES, 1: extra cycles inserted before the first ack of every cycle (0..15).

Ports:
- wb_clk_i  in  1  bus clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- s_wb_adr_i  in  32  byte address; bits [1:0] ignored.
- s_wb_sel_i  in  4  byte-lane selects; bit n enables dat[8n+7:8n].
- s_wb_we_i  in  1  1 = write, 0 = read.
- s_wb_dat_i  in  32  write data from master.
- s_wb_dat_o  out  32  read data to master.
- s_wb_cyc_i  in  1  cycle valid.
- s_wb_stb_i  in  1  strobe.
- s_wb_cti_i  in  3  000 classic, 010 incrementing burst, 111 end-of-burst; others treated as classic.
- s_wb_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- s_wb_ack_o  out  1  normal termination.
- s_wb_err_o  out  1  error termination.

Behaviour:
- Reset (wb_rst_i sampled high):
  - ack_o=0, err_o=0, dat_o=0, FSM to IDLE, wait counter=0.
  - Memory array is not cleared.
  - Reset mid-cycle aborts the cycle; no ack or err is issued for it.
- Request = cyc_i & stb_i. Word index = (adr_i - BASE_ADDR) >> 2. In range iff adr_i >= BASE_ADDR and index < DEPTH.
- FSM states:
  - IDLE:
    - On request with out-of-range address: go to ERR.
    - Else if WAIT_STATES=0: go to ACK.
    - Else: go to WAIT, wait counter loaded with WAIT_STATES-1.
  - WAIT:
    - Counter decrements each cycle.
    - At 0: go to ACK.
    - Request dropped at any point: go to IDLE, no termination.
  - ACK:
    - ack_o=1 for this cycle. Read data is valid on dat_o in the same cycle, registered from the array.
    - Write: the array is updated at the end of the ack cycle, honouring sel_i. sel_i=0000 acks without modifying memory.
    - Transition: if cti_i=010, burst enabled, and stb_i still high, go to BURST with an internal next address. Otherwise go to GAP.
  - BURST:
    - ack_o=1 every cycle with stb_i high; one beat per cycle, zero wait states.
    - Internal address increments by one word per beat. For bte≠00, only the low log2(4/8/16) word-index bits increment; upper bits are held.
    - stb_i low in a cycle: ack_o=0 in that cycle, address held.
    - cti_i=111 sampled with ack: go to GAP after that beat.
    - Linear burst next address leaving range: go to ERR instead of ACK for that beat.
    - cyc_i low: go to IDLE immediately.
  - GAP: one-cycle dead state (ack_o=0) so a held stb is not double-acked; then go to IDLE.
  - ERR:
    - err_o=1 for one cycle; no memory write; dat_o holds its previous value.
    - Then go to GAP.
- ack_o and err_o are mutually exclusive and registered.
- Classic read latency = WAIT_STATES+1 cycles from the request-sampling edge.

Optional Feature:
- Macro: WB_BURST_SLAVE_MEM_BURST_EN.
- Defined: BURST state and CTI/BTE handling as specified above.
- Undefined:
  - cti_i and bte_i are ignored.
  - Every beat is handled as a classic cycle: IDLE, then WAIT, then ACK, then GAP.
  - Each beat pays WAIT_STATES+1 cycles of latency plus the GAP cycle.

Test Plan:
- Reset, WAIT_STATES=1: write 32'hDEADBEEF to BASE+0x10 with sel=1111, then read it back.
  - Each ack arrives exactly 2 cycles after the request edge.
  - Read returns DEADBEEF.
- Partial write: preload 32'h11223344, write 32'hAABBCCDD with sel=0101 to the same address.
  - Readback = 32'h11BB33DD.
- Incrementing linear burst, 4 beats at BASE+0x00, cti=010,010,010,111.
  - First ack after 2 cycles, then 3 consecutive acks.
  - Words 0..3 are written in order; FSM passes through GAP and ends in IDLE.
- Wrap4 read burst starting at word 6 with DEPTH=1024.
  - Data returned from words 6,7,4,5 on consecutive acks.
- Out-of-range read at BASE+4*DEPTH.
  - err_o=1 for exactly one cycle; ack_o stays 0; memory unchanged.
- wb_rst_i asserted during the WAIT state of a write.
  - No ack or err is issued.
  - The targeted word keeps its old value.
  - The next request is serviced normally.
